pci_initiator: RTL

- Bus-master (initiator) end of the team's simplified PCI-style bus; drives the command, address and data phases that the target buffer block responds to.
- Accepts one burst request at a time from a local client: READ (CBE 4'b0110) or WRITE (CBE 4'b0111), start address, word count.
- Runs the FRAME/IRDY/TRDY handshake and streams data words to or from the client.
- Guards each data phase with a target-wait timeout.

---
 rtl/pci_initiator.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pci_initiator.sv
// Bus-master end of the simplified PCI-style bus: runs address, turnaround and
// data phases for one client burst at a time, with a per-beat target-wait timeout.
//
// state | meaning
// IDLE  | waiting for a client request, req_ready high
// ADDR  | address phase: FRAME low, AD = address, CBE = command
// TURN  | read turnaround: AD released, IRDY low, target takes over AD
// DATA  | data beats; a beat completes on IRDY low & TRDY low
// FIN   | one-cycle done pulse (err set on timeout or zero length)
module pci_initiator #(
    parameter int LEN_W    = 5,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [31:0]      wr_data,
    output logic [LEN_W-1:0] beat_idx,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic [LEN_W-1:0] rd_idx,
    output logic             done,
    output logic             err,
    output logic             frame,
    output logic [3:0]       CBE,
    inout  wire  [31:0]      AD,
    output logic             IRDY,
    input  logic             TRDY
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MAX_WAIT - 1);
    localparam logic [3:0] CMD_READ  = 4'b0110;
    localparam logic [3:0] CMD_WRITE = 4'b0111;
    localparam logic [3:0] BE_ALL    = 4'b0000;
    localparam logic [3:0] BE_IDLE   = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_TURN,
        S_DATA,
        S_FIN
    } state_t;

    state_t            state;
    logic              is_write;
    logic [31:0]       addr_q;
    logic [LEN_W-1:0]  last_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ad_oe;
    logic              ad_wsel;

    // Output enable and source select are registered; write data passes
    // straight through so it tracks beat_idx in the same cycle.
    assign AD = ad_oe ? (ad_wsel ? wr_data : addr_q) : {32{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            is_write  <= 1'b0;
            addr_q    <= '0;
            last_idx  <= '0;
            wait_cnt  <= WAIT_LOAD;
            ad_oe     <= 1'b0;
            ad_wsel   <= 1'b0;
            req_ready <= 1'b1;
            beat_idx  <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_idx    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            frame     <= 1'b1;
            IRDY      <= 1'b1;
            CBE       <= BE_IDLE;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        beat_idx  <= '0;
                        if (req_len == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state    <= S_ADDR;
                            is_write <= req_write;
                            addr_q   <= req_addr;
                            last_idx <= req_len - 1'b1;
                            frame    <= 1'b0;
                            IRDY     <= 1'b1;
                            CBE      <= req_write ? CMD_WRITE : CMD_READ;
                            ad_oe    <= 1'b1;
                            ad_wsel  <= 1'b0;
                        end
                    end
                end
                S_ADDR: begin
                    CBE      <= BE_ALL;
                    IRDY     <= 1'b0;
                    wait_cnt <= WAIT_LOAD;
                    if (is_write) begin
                        state   <= S_DATA;
                        ad_wsel <= 1'b1;
                        frame   <= (last_idx == '0);
                    end else begin
                        state <= S_TURN;
                        ad_oe <= 1'b0;
                    end
                end
                S_TURN: begin
                    state    <= S_DATA;
                    frame    <= (last_idx == '0);
                    wait_cnt <= WAIT_LOAD;
                end
                S_DATA: begin
                    if (!TRDY) begin
                        beat_idx <= beat_idx + 1'b1;
                        wait_cnt <= WAIT_LOAD;
                        if (!is_write) begin
                            rd_data  <= AD;
                            rd_valid <= 1'b1;
                            rd_idx   <= beat_idx;
                        end
                        if (beat_idx == last_idx) begin
                            state   <= S_FIN;
                            done    <= 1'b1;
                            frame   <= 1'b1;
                            IRDY    <= 1'b1;
                            CBE     <= BE_IDLE;
                            ad_oe   <= 1'b0;
                            ad_wsel <= 1'b0;
                        end else if (beat_idx + 1'b1 == last_idx) begin
                            frame <= 1'b1;
                        end
                    end else if (wait_cnt == '0) begin
                        // Target never became ready: abandon the burst.
                        state   <= S_FIN;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        frame   <= 1'b1;
                        IRDY    <= 1'b1;
                        CBE     <= BE_IDLE;
                        ad_oe   <= 1'b0;
                        ad_wsel <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_FIN: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
